display_scan_controller: RTL and testbench
==========================================

# display_scan_controller

Sequencer for the 8-digit multiplexed seven-segment display. It generates the 3-bit digit index that feeds the anode decoder and sequences each slot through show and blank phases. It supplies the current digit's hex nibble from a double-buffered frame register. A valid/ready load port updates that register, and new frames take effect only at frame boundaries, so the display never tears.

## Interface
- SHOW_CYCLES, 90000, clock cycles a digit is lit per slot; must be ≥ 1
- BLANK_CYCLES, 10000, anti-ghosting blank cycles after each show phase; 0 removes the BLANK phase
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  scanning enabled; 0 forces IDLE with all digits blanked
- digit_mask  in  8  per-digit show enable, bit i = digit i; sampled only at frame start
- load_valid  in  1  load_data is offered
- load_data  in  32  eight nibbles, digit i = bits [4i+3:4i]
- load_ready  out  1  shadow buffer empty; equals !pending_full
- refresh_counter  out  3  current digit index for the anode decoder
- digit_blank  out  1  1 = drive no anode this cycle
- nibble  out  4  hex value of the current digit
- frame_start  out  1  one-cycle pulse in the first SHOW cycle of digit 0

## Operation
- Reset values:
  - refresh_counter=0, digit_blank=1, nibble=0, frame_start=0.
  - active_data=0, active_mask=0, pending_full=0, so load_ready=1.
  - State is IDLE.
- All outputs except load_ready are registered.
- States:
  - **IDLE:** refresh_counter=0, digit_blank=1. When enable=1 → SHOW with index 0 and frame-start actions.
  - **SHOW:** runs SHOW_CYCLES cycles. digit_blank=!active_mask[idx]. nibble=active_data[4·idx+:4]. Exit → BLANK, or to the next SHOW if BLANK_CYCLES=0.
  - **BLANK:** runs BLANK_CYCLES cycles with digit_blank=1. refresh_counter holds idx. Exit → SHOW with idx+1 mod 8.
- Frame-start actions apply on every entry into SHOW with idx=0, including from IDLE:
  - active_mask ← digit_mask.
  - If pending_full: active_data ← shadow, pending_full ← 0.
  - frame_start=1 for that cycle.
- Wrap-around: idx 7 → 0 is a frame boundary.
- Masked digits keep their slot time (blanked), so the frame period stays constant at 8·(SHOW_CYCLES+BLANK_CYCLES).
- Load handshake:
  - A transfer occurs when load_valid && load_ready: shadow ← load_data, pending_full ← 1.
  - load_data may change freely while load_ready=0.
  - A load accepted in the same cycle as a frame start is not applied at that boundary; it is applied at the next one.
  - Loads are accepted while in IDLE and applied on the next entry into SHOW.
- enable low in any state:
  - Next cycle the state is IDLE with digit_blank=1 and refresh_counter=0.
  - The slot timer clears.
  - active_data and pending data are retained.
- reset mid-frame: all state returns to reset values next cycle and any pending load is discarded.

## Timing
- Latency from enable sampled high at cycle t:
  - refresh_counter=0, frame_start=1 and SHOW begin at t+1.
  - nibble and digit_blank reflect the frame-start update at t+1.
- Slot timer counts are exact: SHOW for exactly SHOW_CYCLES cycles, BLANK for exactly BLANK_CYCLES cycles.
- digit_blank, nibble and refresh_counter change in the same cycle, so there is no skew between index and data.
- load_ready deasserts the cycle after a transfer. It reasserts in the first SHOW cycle of the next frame.
- Timer width is $clog2(max(SHOW_CYCLES, BLANK_CYCLES)+1). Index arithmetic is 3-bit modulo-8.

## Structure
- Package display_pkg holds:
  - NUM_DIGITS=8, IDX_W=3, NIBBLE_W=4.
  - The scan_state_t enum {IDLE, SHOW, BLANK}.
- One sub-module, slot_timer: a loadable down-counter with a done pulse, reloaded on each state entry and cleared by reset or enable=0.
- The FSM, index register, mask and data buffers stay in the top.

## Test plan
Bench parameters: SHOW_CYCLES=4, BLANK_CYCLES=2.
- **Reset/idle:** reset, enable=0 → digit_blank=1, refresh_counter=0, load_ready=1, frame_start never pulses.
- **Full frame:**
  - Load 0x76543210, then raise enable with mask 0xFF.
  - Expected: frame_start at t+1; refresh_counter steps 0..7 every 6 cycles; nibble equals the index during the 4 show cycles, then 2 blank cycles.
  - Wrap to 0 after 48 cycles with a frame_start pulse.
- **Mask:** mask 0x0F → digits 4-7 keep digit_blank=1 through their full 6-cycle slots; the frame period stays 48.
- **Tear-free load:**
  - Load 0xAAAAAAAA mid-frame → load_ready drops; nibble stays at the old values until the next frame_start, then shows 0xA; load_ready returns to 1.
  - A second load offered while load_ready=0 is held off until then.
- **Boundary collision:** a load accepted in the exact frame_start cycle is applied only at the following frame_start, 48 cycles later.
- **Disable/reset mid-slot:**
  - Enable dropped at digit 5 show cycle 2 → next cycle digit_blank=1, refresh_counter=0.
  - Re-enable restarts at digit 0 with frame_start.
  - Reset with a pending load → load_ready=1 and the old load is discarded.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared constants and scan state type for the seven-segment scan controller
package display_pkg;
    localparam int NUM_DIGITS = 8;
    localparam int IDX_W = 3;
    localparam int NIBBLE_W = 4;
    typedef enum logic [1:0] {IDLE, SHOW, BLANK} scan_state_t;
endpackage

// File: rtl/display_scan_controller_slot_timer.sv
// slot_timer: loadable down-counter whose done flag marks the last cycle of a phase
module slot_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_value_i,
    output logic         done_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clear_i ? '0 : load_i ? load_value_i : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end

    assign done_o = cnt_q == '0;
endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: 8-digit multiplexed display sequencer with tear-free double-buffered frames
module display_scan_controller
    import display_pkg::*;
#(
    parameter int SHOW_CYCLES  = 90000,
    parameter int BLANK_CYCLES = 10000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_DIGITS-1:0]         digit_mask,
    input  logic                          load_valid,
    input  logic [NUM_DIGITS*NIBBLE_W-1:0] load_data,
    output logic                          load_ready,
    output logic [IDX_W-1:0]              refresh_counter,
    output logic                          digit_blank,
    output logic [NIBBLE_W-1:0]           nibble,
    output logic                          frame_start
);
    localparam int MAXC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int TW = $clog2(MAXC + 1);
    localparam logic [TW-1:0] SHOW_LD = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_LD = TW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    scan_state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [NUM_DIGITS-1:0] active_mask_q, active_mask_d;
    logic [NUM_DIGITS*NIBBLE_W-1:0] active_data_q, active_data_d, shadow_q, shadow_d;
    logic pending_q, pending_d;
    logic [IDX_W-1:0] refresh_counter_q, refresh_counter_d;
    logic digit_blank_q, digit_blank_d;
    logic [NIBBLE_W-1:0] nibble_q, nibble_d;
    logic frame_start_q, frame_start_d;
    logic done, timer_load, xfer;

    slot_timer #(.W(TW)) u_timer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (!enable),
        .load_i       (timer_load),
        .load_value_i (state_d == SHOW ? SHOW_LD : BLANK_LD),
        .done_o       (done)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        if (!enable) begin
            state_d = IDLE;
            idx_d = '0;
        end else if (state_q == IDLE) begin
            state_d = SHOW;
            idx_d = '0;
        end else if (done) begin
            state_d = (state_q == SHOW && BLANK_CYCLES > 0) ? BLANK : SHOW;
            idx_d = (state_q == SHOW && BLANK_CYCLES > 0) ? idx_q : idx_q + 1'b1;
        end
    end

    // every entry into SHOW at index 0 is a frame boundary, including the first one out of IDLE
    always_comb begin
        timer_load = enable && (state_q == IDLE || done);
        frame_start_d = enable && (state_q == IDLE || (done && state_d == SHOW && idx_q == LAST_IDX));
        xfer = load_valid && !pending_q;
        active_mask_d = frame_start_d ? digit_mask : active_mask_q;
        active_data_d = (frame_start_d && pending_q) ? shadow_q : active_data_q;
        pending_d = xfer ? 1'b1 : (frame_start_d ? 1'b0 : pending_q);
        shadow_d = xfer ? load_data : shadow_q;
        refresh_counter_d = state_d == IDLE ? '0 : idx_d;
        digit_blank_d = state_d == SHOW ? !active_mask_d[idx_d] : 1'b1;
        nibble_d = active_data_d[NIBBLE_W*idx_d +: NIBBLE_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
            active_mask_q <= '0;
            active_data_q <= '0;
            shadow_q <= '0;
            pending_q <= 1'b0;
            refresh_counter_q <= '0;
            digit_blank_q <= 1'b1;
            nibble_q <= '0;
            frame_start_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            active_mask_q <= active_mask_d;
            active_data_q <= active_data_d;
            shadow_q <= shadow_d;
            pending_q <= pending_d;
            refresh_counter_q <= refresh_counter_d;
            digit_blank_q <= digit_blank_d;
            nibble_q <= nibble_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign load_ready = !pending_q;
    assign refresh_counter = refresh_counter_q;
    assign digit_blank = digit_blank_q;
    assign nibble = nibble_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: random and directed stimulus checked against a frame-position reference model
module tb_display_scan_controller;
    localparam int S = 4;
    localparam int B = 2;
    localparam int SLOT = S + B;
    localparam int FRAME = 8 * SLOT;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic [7:0] digit_mask = '0;
    logic load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic load_ready;
    logic [2:0] refresh_counter;
    logic digit_blank;
    logic [3:0] nibble;
    logic frame_start;

    int checks = 0;
    int errors = 0;

    bit running = 0;
    int pos = 0;
    bit m_fs = 0;
    bit m_pend = 0;
    logic [7:0] m_mask = '0;
    logic [31:0] m_active = '0;
    logic [31:0] m_shadow = '0;

    display_scan_controller #(.SHOW_CYCLES(S), .BLANK_CYCLES(B)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .digit_mask      (digit_mask),
        .load_valid      (load_valid),
        .load_data       (load_data),
        .load_ready      (load_ready),
        .refresh_counter (refresh_counter),
        .digit_blank     (digit_blank),
        .nibble          (nibble),
        .frame_start     (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // model tracks position within the frame; state, index and blanking follow from it
    task automatic model_step();
        bit xfer;
        if (reset) begin
            running = 0; pos = 0; m_fs = 0; m_pend = 0; m_mask = '0; m_active = '0; m_shadow = '0;
        end else begin
            xfer = load_valid && !m_pend;
            if (!enable) begin
                running = 0; pos = 0; m_fs = 0;
            end else if (!running) begin
                running = 1; pos = 0; m_fs = 1;
            end else begin
                pos = (pos + 1) % FRAME;
                m_fs = (pos == 0);
            end
            if (m_fs) begin
                m_mask = digit_mask;
                if (m_pend) begin
                    m_active = m_shadow;
                    m_pend = 0;
                end
            end
            if (xfer) begin
                m_shadow = load_data;
                m_pend = 1;
            end
        end
    endtask

    task automatic compare();
        int slot;
        bit show;
        slot = pos / SLOT;
        show = (pos % SLOT) < S;
        check("refresh_counter", refresh_counter, running ? slot : 0);
        check("digit_blank", digit_blank, running ? (!show || !m_mask[slot]) : 1'b1);
        check("frame_start", frame_start, running ? m_fs : 1'b0);
        check("load_ready", load_ready, !m_pend);
        if (running && show) check("nibble", nibble, (m_active >> (4 * slot)) & 32'hF);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic run_to(input int p);
        for (int i = 0; i < FRAME + 12 && !(running && pos == p); i++) tick();
        check("run_to_pos", running ? pos : -1, p);
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        load_valid = 1'b1;
        load_data = 32'h76543210;
        tick();
        load_valid = 1'b0;
        check("ready_after_load", load_ready, 1'b0);
        enable = 1'b1;
        digit_mask = 8'hFF;
        tick();
        check("first_frame_start", frame_start, 1'b1);
        check("first_nibble", nibble, 4'h0);
        repeat (100) tick();
        digit_mask = 8'h0F;
        repeat (100) tick();
        run_to(10);
        load_valid = 1'b1;
        load_data = 32'hAAAAAAAA;
        tick();
        load_data = 32'h55555555;
        repeat (60) tick();
        load_valid = 1'b0;
        repeat (60) tick();
        run_to(0);
        load_valid = 1'b1;
        load_data = 32'h13579BDF;
        tick();
        load_valid = 1'b0;
        repeat (100) tick();
        digit_mask = 8'hFF;
        run_to(5 * SLOT + 1);
        enable = 1'b0;
        tick();
        check("disable_blank", digit_blank, 1'b1);
        check("disable_index", refresh_counter, 3'd0);
        repeat (3) tick();
        enable = 1'b1;
        tick();
        check("reenable_frame_start", frame_start, 1'b1);
        run_to(10);
        load_valid = 1'b1;
        load_data = $urandom;
        tick();
        load_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_ready", load_ready, 1'b1);
        repeat (60) tick();
        repeat (3000) begin
            enable = $urandom_range(0, 99) < 97;
            reset = $urandom_range(0, 199) == 0;
            load_valid = $urandom_range(0, 3) == 0;
            load_data = $urandom;
            if ($urandom_range(0, 49) == 0) digit_mask = 8'($urandom);
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
